// File: rtl/age_matrix_scheduler_pkg.sv
// Shared types and helpers for the age-matrix issue scheduler.
// Holds the fixed upper bounds and the one-hot to index encoder.
// No logic state lives here.
package age_matrix_scheduler_pkg;

  // Upper bounds supported by the generic helpers below.
  localparam int MAX_ENTRIES     = 64;
  localparam int IDX_MAX_W       = 6;
  localparam int MAX_ALLOC_WIDTH = 4;

  // Row of the age matrix for the default 8-entry bank.
  localparam int DEF_NUM_ENTRIES = 8;
  typedef logic [DEF_NUM_ENTRIES-1:0] age_row_t;

  // Encodes a one-hot (or all-zero) vector; all-zero yields index 0.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_ENTRIES-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (oh[i]) idx = idx | IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/age_matrix_scheduler_if.sv
// Allocation / issue bundle between the upstream, the issue stage and the scheduler.
// Latency: wires only.  Backpressure: issue_ready from the issue stage.
// Ports: flush, alloc_valid/alloc_idx, ready_entries, issue_valid/idx/ready,
//        valid_entries, occupancy, alloc_err.
interface age_matrix_scheduler_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int ALLOC_WIDTH = 2
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  logic                         flush;
  logic [ALLOC_WIDTH-1:0]       alloc_valid;
  logic [ALLOC_WIDTH*IDX_W-1:0] alloc_idx;
  logic [NUM_ENTRIES-1:0]       ready_entries;
  logic                         issue_valid;
  logic [IDX_W-1:0]             issue_idx;
  logic                         issue_ready;
  logic [NUM_ENTRIES-1:0]       valid_entries;
  logic [OCC_W-1:0]             occupancy;
  logic                         alloc_err;

  // master: upstream + issue stage side; slave: the scheduler.
  modport master (
    output flush, alloc_valid, alloc_idx, ready_entries, issue_ready,
    input  issue_valid, issue_idx, valid_entries, occupancy, alloc_err
  );

  modport slave (
    input  flush, alloc_valid, alloc_idx, ready_entries, issue_ready,
    output issue_valid, issue_idx, valid_entries, occupancy, alloc_err
  );

endinterface

// File: rtl/age_matrix_scheduler_age_pick.sv
// Oldest-eligible picker over an age matrix (age_i[i][j]=1: i older than j).
// Latency: purely combinational.  Backpressure: none.
// Ports: age_i matrix, elig_i eligible vector -> win_o one-hot winner, any_o.
module age_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0][N-1:0] age_i,
  input  logic [N-1:0]        elig_i,
  output logic [N-1:0]        win_o,
  output logic                any_o
);

  logic [N-1:0] col;

  // Slot i wins when no other eligible slot is older than it.  Rows of
  // freed slots hold stale bits, but they are masked by elig_i.
  always_comb begin
    col   = '0;
    win_o = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        col[j] = age_i[j][i];
      end
      win_o[i] = elig_i[i] & ~|(col & elig_i);
    end
  end

  assign any_o = |elig_i;

endmodule

// File: rtl/age_matrix_scheduler.sv
// Age-ordered issue selector for one reservation-station bank.
// Latency: alloc in cycle N is grantable in N+1; grant is combinational, free on accept edge.
// Backpressure: grant held (not freed) while issue_ready=0; flush drops allocs/accept.
// Ports: clk, reset (async, active-high), bus (slave side of age_matrix_scheduler_if).
module age_matrix_scheduler
  import age_matrix_scheduler_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,   // 2 .. MAX_ENTRIES
  parameter int ALLOC_WIDTH = 2    // 1 .. MAX_ALLOC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  age_matrix_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  // State
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;
  logic [NUM_ENTRIES-1:0]                  valid_q, valid_d;
  logic [OCC_W-1:0]                        occ_q, occ_d;
  logic                                    err_q, err_d;

  // Grant path
  logic [NUM_ENTRIES-1:0] elig;
  logic [NUM_ENTRIES-1:0] win_oh;
  logic                   any_elig;
  logic                   accept;
  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] surv;

  // Allocation path
  logic [NUM_ENTRIES-1:0] older;
  logic [IDX_W-1:0]       slot;
  logic [OCC_W-1:0]       alloc_cnt;
  logic                   bad_alloc;

  assign elig = valid_q & bus.ready_entries;

  age_pick #(
    .N (NUM_ENTRIES)
  ) u_pick (
    .age_i  (age_q),
    .elig_i (elig),
    .win_o  (win_oh),
    .any_o  (any_elig)
  );

  // A flushed cycle never frees anything on its own; the flush clears all.
  assign accept   = any_elig & bus.issue_ready & ~bus.flush;
  assign free_vec = accept ? win_oh : '0;
  assign surv     = valid_q & ~free_vec;

  // Ports are walked in order; 'older' accumulates every slot that is older
  // than the one being placed: survivors plus slots taken by lower ports.
  // A slot freed by this cycle's accept is not in 'older', so it can be
  // reallocated and becomes the youngest.
  always_comb begin
    age_d     = age_q;
    older     = surv;
    alloc_cnt = '0;
    bad_alloc = 1'b0;
    slot      = '0;
    for (int p = 0; p < ALLOC_WIDTH; p++) begin
      slot = bus.alloc_idx[p*IDX_W +: IDX_W];
      if (bus.alloc_valid[p]) begin
        if ((int'(slot) >= NUM_ENTRIES) || older[slot]) begin
          bad_alloc = 1'b1;
        end else begin
          age_d[slot] = '0;
          // Diagonal stays 0 because older[slot] is 0 here.
          for (int j = 0; j < NUM_ENTRIES; j++) begin
            age_d[j][slot] = older[j];
          end
          older[slot] = 1'b1;
          alloc_cnt   = alloc_cnt + OCC_W'(1);
        end
      end
    end
  end

  always_comb begin
    valid_d = older;
    occ_d   = occ_q + alloc_cnt - OCC_W'(accept);
    err_d   = err_q | bad_alloc;
    if (bus.flush) begin
      valid_d = '0;
      occ_d   = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q   <= '0;
      valid_q <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // Matrix contents are irrelevant once everything is invalid.
      if (!bus.flush) age_q <= age_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  assign bus.issue_valid   = any_elig;
  assign bus.issue_idx     = IDX_W'(onehot_to_idx(MAX_ENTRIES'(win_oh)));
  assign bus.valid_entries = valid_q;
  assign bus.occupancy     = occ_q;
  assign bus.alloc_err     = err_q;

endmodule
